ds2x2_engine: RTL and testbench



---
 rtl/ds2x2_engine.sv | 189 ++++++++++++++++++
 tb/tb_ds2x2_engine.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ds2x2_engine.sv
`default_nettype none
// ============================================================================
// Module      : ds2x2_engine
// Description : 2x2 downsample engine. It reads the top row of each 2x2 block
//               through RAM port A and the bottom row through port B. It then
//               writes one reduced pixel per block back through port A.
//               Optional macro DS_MAXPOOL_EN selects a max-pool reduction
//               instead of the default rounded average.
// Revision    : 1.0 - initial release
// ============================================================================
module ds2x2_engine #(
  parameter int ADDR_W = 19,
  parameter int DIM_W  = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DIM_W-1:0]  img_w,
  input  logic [DIM_W-1:0]  img_h,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr_a,
  output logic [ADDR_W-1:0] ram_addr_b,
  output logic              ram_we_a,
  output logic              ram_we_b,
  output logic [7:0]        ram_data_a,
  output logic [7:0]        ram_data_b,
  input  logic [7:0]        ram_q_a,
  input  logic [7:0]        ram_q_b
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD_L = 3'd1,
    RD_R = 3'd2,
    ACC  = 3'd3,
    WR   = 3'd4,
    FIN  = 3'd5
  } state_t;

  state_t            state;
  logic [DIM_W-1:0]  ow;        // output width  = floor(img_w/2)
  logic [DIM_W-1:0]  oh;        // output height = floor(img_h/2)
  logic [DIM_W-1:0]  ox;
  logic [DIM_W-1:0]  oy;
  logic [ADDR_W-1:0] row_w;     // source row pitch, widened to address width
  logic [ADDR_W-1:0] rowp;      // address of the top-left pixel of the current block row
  logic [ADDR_W-1:0] src_ptr;   // address of the top-left pixel of the current block
  logic [ADDR_W-1:0] dst_ptr;   // address of the current output pixel
  logic [9:0]        sum;       // partial result after the left column pair

  logic [ADDR_W-1:0] in_w_ext;
  logic [ADDR_W-1:0] next_rowp;
  logic [ADDR_W-1:0] next_src;
  logic              last_col;
  logic              last_row;
  logic              degenerate;
  logic [9:0]        pair_val;
  logic [7:0]        blk_val;

  // Address steppers and end-of-row/end-of-image detection.
  always_comb begin
    in_w_ext   = ADDR_W'(img_w);
    next_rowp  = rowp + (row_w << 1);
    next_src   = src_ptr + ADDR_W'(2);
    last_col   = (ox == ow - DIM_W'(1));
    last_row   = (oy == oh - DIM_W'(1));
    degenerate = (img_w < DIM_W'(2)) || (img_h < DIM_W'(2));
  end

  // Reduction of the column pair currently on the RAM outputs.
  // pair_val seeds the accumulator and blk_val is the final pixel.
  always_comb begin
    pair_val = 10'd0;
    blk_val  = 8'd0;
`ifdef DS_MAXPOOL_EN
    pair_val = (ram_q_a > ram_q_b) ? {2'b00, ram_q_a} : {2'b00, ram_q_b};
    blk_val  = 8'((sum > pair_val) ? sum : pair_val);
`else
    pair_val = {1'b0, ({1'b0, ram_q_a} + {1'b0, ram_q_b})};
    // Round half up; a sum of four bytes plus 2 fits in 10 bits.
    blk_val  = 8'((sum + {2'b00, ram_q_a} + {2'b00, ram_q_b} + 10'd2) >> 2);
`endif
  end

  assign ram_we_b   = 1'b0;
  assign ram_data_b = 8'd0;

  // Control FSM. All RAM-facing outputs are registered.
  // Read addresses for the next block are loaded on the edge that enters RD_L.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      ram_we_a   <= 1'b0;
      ram_addr_a <= '0;
      ram_addr_b <= '0;
      ram_data_a <= 8'd0;
      ow         <= '0;
      oh         <= '0;
      ox         <= '0;
      oy         <= '0;
      row_w      <= '0;
      rowp       <= '0;
      src_ptr    <= '0;
      dst_ptr    <= '0;
      sum        <= 10'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            row_w   <= in_w_ext;
            ow      <= img_w >> 1;
            oh      <= img_h >> 1;
            ox      <= '0;
            oy      <= '0;
            rowp    <= src_base;
            src_ptr <= src_base;
            dst_ptr <= dst_base;
            if (degenerate) begin
              // Nothing to produce: report completion without touching RAM.
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state      <= RD_L;
              busy       <= 1'b1;
              ram_addr_a <= src_base;
              ram_addr_b <= src_base + in_w_ext;
            end
          end
        end
        RD_L: begin
          ram_addr_a <= ram_addr_a + ADDR_W'(1);
          ram_addr_b <= ram_addr_b + ADDR_W'(1);
          state      <= RD_R;
        end
        RD_R: begin
          sum   <= pair_val;
          state <= ACC;
        end
        ACC: begin
          ram_data_a <= blk_val;
          ram_addr_a <= dst_ptr;
          ram_we_a   <= 1'b1;
          state      <= WR;
        end
        WR: begin
          ram_we_a <= 1'b0;
          dst_ptr  <= dst_ptr + ADDR_W'(1);
          if (last_col) begin
            ox         <= '0;
            oy         <= oy + DIM_W'(1);
            rowp       <= next_rowp;
            src_ptr    <= next_rowp;
            ram_addr_a <= next_rowp;
            ram_addr_b <= next_rowp + row_w;
            if (last_row) begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= RD_L;
            end
          end else begin
            ox         <= ox + DIM_W'(1);
            src_ptr    <= next_src;
            ram_addr_a <= next_src;
            ram_addr_b <= next_src + row_w;
            state      <= RD_L;
          end
        end
        FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ds2x2_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_ds2x2_engine
// Description : Self-checking bench for ds2x2_engine. It contains a
//               behavioural dual-port RAM and a reference model that works at
//               the image level: block pixel values, write cycles and
//               busy/done windows.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ds2x2_engine;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [9:0]  img_w;
  logic [9:0]  img_h;
  logic [18:0] src_base;
  logic [18:0] dst_base;
  logic        busy;
  logic        done;
  logic [18:0] ram_addr_a;
  logic [18:0] ram_addr_b;
  logic        ram_we_a;
  logic        ram_we_b;
  logic [7:0]  ram_data_a;
  logic [7:0]  ram_data_b;
  logic [7:0]  ram_q_a;
  logic [7:0]  ram_q_b;

  logic [7:0]  mem [0:524287];
  logic [7:0]  img [0:15][0:15];
  int          checks;
  int          failures;

  ds2x2_engine #(.ADDR_W(19), .DIM_W(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .img_w      (img_w),
    .img_h      (img_h),
    .src_base   (src_base),
    .dst_base   (dst_base),
    .busy       (busy),
    .done       (done),
    .ram_addr_a (ram_addr_a),
    .ram_addr_b (ram_addr_b),
    .ram_we_a   (ram_we_a),
    .ram_we_b   (ram_we_b),
    .ram_data_a (ram_data_a),
    .ram_data_b (ram_data_b),
    .ram_q_a    (ram_q_a),
    .ram_q_b    (ram_q_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered read ports with one cycle of latency. Writes are applied by the
  // job monitor when it sees ram_we_a.
  always @(posedge clk) begin
    ram_q_a <= mem[ram_addr_a];
    ram_q_b <= mem[ram_addr_b];
  end

  // Expected reduced value of output block (bx,by).
  function automatic logic [7:0] ref_pix(int bx, int by);
    int p0, p1, p2, p3;
    p0 = int'(img[2*by][2*bx]);
    p1 = int'(img[2*by][2*bx+1]);
    p2 = int'(img[2*by+1][2*bx]);
    p3 = int'(img[2*by+1][2*bx+1]);
`ifdef DS_MAXPOOL_EN
    begin
      int m;
      m = p0;
      if (p1 > m) m = p1;
      if (p2 > m) m = p2;
      if (p3 > m) m = p3;
      return 8'(m);
    end
`else
    return 8'((p0 + p1 + p2 + p3 + 2) / 4);
`endif
  endfunction

  // True when address a lies inside the part of the source image that is
  // covered by whole 2x2 blocks.
  function automatic bit in_src(logic [18:0] a, logic [18:0] src, int w, int h);
    logic [18:0] off;
    int o;
    off = a - src;
    o = int'(off);
    if (o >= w * h) return 1'b0;
    return ((o % w) < 2 * (w / 2)) && ((o / w) < 2 * (h / 2));
  endfunction

  task automatic load_img(input int w, input int h, input logic [18:0] src);
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        mem[src + 19'(y * w + x)] = img[y][x];
  endtask

  // Runs one job. It checks busy/done, every write (cycle, address and data),
  // and the addresses of all source reads against the reference model.
  // mid_start > 0 re-asserts start during that cycle.
  // rst_cycle > 0 drops rst_n during that cycle.
  task automatic run_job(input string name, input int w, input int h,
                         input logic [18:0] src, input logic [18:0] dst,
                         input int mid_start, input int rst_cycle);
    int ow, oh, n, c_end;
    bit bad_addr, bad_b;
    ow = w / 2;
    oh = h / 2;
    n  = ow * oh;
    c_end = 4 * n + 4;
    if (rst_cycle > 0) c_end = rst_cycle + 4;
    bad_addr = 1'b0;
    bad_b    = 1'b0;
    load_img(w, h, src);
    @(negedge clk);
    img_w    = 10'(w);
    img_h    = 10'(h);
    src_base = src;
    dst_base = dst;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 1; c <= c_end; c++) begin
      bit live, exp_busy, exp_done, exp_wr;
      int k;
      if (c > 1) begin
        @(posedge clk);
        #1;
      end
      live     = (rst_cycle == 0) || (c <= rst_cycle);
      exp_busy = live && (c <= 4 * n);
      exp_done = live && (c == 4 * n + 1);
      exp_wr   = live && (n > 0) && (c % 4 == 0) && (c <= 4 * n);
      k        = c / 4 - 1;
      checks++;
      if (busy !== exp_busy || done !== exp_done) begin
        failures++;
        $display("FAIL %s busy/done cycle %0d: got %b/%b expected %b/%b",
                 name, c, busy, done, exp_busy, exp_done);
      end
      checks++;
      if (ram_we_a !== exp_wr) begin
        failures++;
        $display("FAIL %s we_a cycle %0d: got %b expected %b", name, c, ram_we_a, exp_wr);
      end
      if (exp_wr && ram_we_a === 1'b1) begin
        logic [18:0] ea;
        logic [7:0]  ed;
        ea = dst + 19'(k);
        ed = ref_pix(k % ow, k / ow);
        checks++;
        if (ram_addr_a !== ea || ram_data_a !== ed) begin
          failures++;
          $display("FAIL %s write %0d: got addr %0d data %0d expected addr %0d data %0d",
                   name, k, ram_addr_a, ram_data_a, ea, ed);
        end
      end
      if (ram_we_a === 1'b1) mem[ram_addr_a] = ram_data_a;
      if (busy === 1'b1) begin
        if (ram_we_a !== 1'b1 && !in_src(ram_addr_a, src, w, h)) bad_addr = 1'b1;
        if (!in_src(ram_addr_b, src, w, h)) bad_addr = 1'b1;
      end
      if (ram_we_b !== 1'b0 || ram_data_b !== 8'd0) bad_b = 1'b1;
      if (mid_start > 0) begin
        if (c == mid_start) begin
          start    = 1'b1;
          img_w    = 10'd2;
          img_h    = 10'd2;
          src_base = src + 19'd500;
          dst_base = dst + 19'd600;
        end else if (c == mid_start + 1) begin
          start = 1'b0;
        end
      end
      if (rst_cycle > 0) begin
        if (c == rst_cycle) rst_n = 1'b0;
        else if (c == rst_cycle + 1) rst_n = 1'b1;
      end
    end
    if (n > 0) begin
      checks++;
      if (bad_addr) begin
        failures++;
        $display("FAIL %s read address outside block area: got out-of-range expected none", name);
      end
    end
    checks++;
    if (bad_b) begin
      failures++;
      $display("FAIL %s port B write: got nonzero we_b/data_b expected 0", name);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || ram_we_a !== 1'b0 ||
        ram_addr_a !== 19'd0 || ram_addr_b !== 19'd0 || ram_data_a !== 8'd0) begin
      failures++;
      $display("FAIL reset: got busy=%b done=%b we=%b aa=%0d ab=%0d d=%0d expected all 0",
               busy, done, ram_we_a, ram_addr_a, ram_addr_b, ram_data_a);
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL idle after reset: got busy=%b done=%b expected 0/0", busy, done);
    end
  endtask

  task automatic test_plan_4x2();
    logic [7:0] e0, e1;
    for (int x = 0; x < 4; x++) begin
      img[0][x] = 8'(10 * (x + 1));
      img[1][x] = 8'(10 * (x + 5));
    end
    mem[1000] = 8'd0;
    mem[1001] = 8'd0;
    run_job("plan4x2", 4, 2, 19'd0, 19'd1000, 0, 0);
`ifdef DS_MAXPOOL_EN
    e0 = 8'd60;
    e1 = 8'd80;
`else
    e0 = 8'd35;
    e1 = 8'd55;
`endif
    checks++;
    if (mem[1000] !== e0 || mem[1001] !== e1) begin
      failures++;
      $display("FAIL plan4x2 result: got %0d,%0d expected %0d,%0d", mem[1000], mem[1001], e0, e1);
    end
  endtask

  task automatic test_all255_5x3();
    for (int y = 0; y < 3; y++)
      for (int x = 0; x < 5; x++)
        img[y][x] = 8'd255;
    mem[2000] = 8'd0;
    mem[2001] = 8'd0;
    run_job("all255", 5, 3, 19'd100, 19'd2000, 0, 0);
    checks++;
    if (mem[2000] !== 8'd255 || mem[2001] !== 8'd255) begin
      failures++;
      $display("FAIL all255 result: got %0d,%0d expected 255,255", mem[2000], mem[2001]);
    end
  endtask

  task automatic test_rounding();
    logic [7:0] e0, e1;
    img[0][0] = 8'd1; img[0][1] = 8'd1; img[1][0] = 8'd1; img[1][1] = 8'd2;
    img[0][2] = 8'd1; img[0][3] = 8'd2; img[1][2] = 8'd2; img[1][3] = 8'd1;
    mem[3000] = 8'hAA;
    mem[3001] = 8'hAA;
    run_job("rounding", 4, 2, 19'd200, 19'd3000, 0, 0);
`ifdef DS_MAXPOOL_EN
    e0 = 8'd2;
    e1 = 8'd2;
`else
    e0 = 8'd1;
    e1 = 8'd2;
`endif
    checks++;
    if (mem[3000] !== e0 || mem[3001] !== e1) begin
      failures++;
      $display("FAIL rounding result: got %0d,%0d expected %0d,%0d", mem[3000], mem[3001], e0, e1);
    end
  endtask

  task automatic test_degenerate();
    run_job("degen1x8", 1, 8, 19'd300, 19'd4000, 0, 0);
    run_job("degen8x1", 8, 1, 19'd300, 19'd4000, 0, 0);
    run_job("degen0x0", 0, 0, 19'd300, 19'd4000, 0, 0);
  endtask

  task automatic test_mid_start();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        img[y][x] = 8'($urandom);
    run_job("midstart", 4, 4, 19'd5000, 19'd6000, 5, 0);
  endtask

  task automatic test_reset_abort();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        img[y][x] = 8'($urandom);
    run_job("abort", 4, 4, 19'd7000, 19'd8000, 0, 6);
    run_job("after_abort", 4, 4, 19'd7000, 19'd8000, 0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      int w, h;
      logic [18:0] src;
      w = int'($urandom_range(2, 13));
      h = int'($urandom_range(2, 11));
      src = (i == 0) ? 19'h7FFF8 : 19'($urandom);
      for (int y = 0; y < h; y++)
        for (int x = 0; x < w; x++)
          img[y][x] = 8'($urandom);
      run_job($sformatf("random%0d_%0dx%0d", i, w, h), w, h, src, src + 19'd300, 0, 0);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    start    = 1'b0;
    img_w    = 10'd0;
    img_h    = 10'd0;
    src_base = 19'd0;
    dst_base = 19'd0;
    test_reset();
    test_plan_4x2();
    test_all255_5x3();
    test_rounding();
    test_degenerate();
    test_mid_start();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
